// File: rtl/rgb_rom_arbiter_if.sv
// Requester-side bundle for rgb_rom_arbiter: two independent lookup
// channels, each a valid/ready request carrying a colour index and a
// one-cycle response pulse carrying the 24-bit RGB word.
//   master : requester view (drives reqN_valid/reqN_colour)
//   slave  : arbiter view (drives reqN_ready, rspN_valid, rspN_rgb)
interface rgb_rom_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 24
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_colour;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rgb;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_colour;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rgb;

    modport master (
        output req0_valid, req0_colour, req1_valid, req1_colour,
        input  req0_ready, rsp0_valid, rsp0_rgb,
        input  req1_ready, rsp1_valid, rsp1_rgb
    );

    modport slave (
        input  req0_valid, req0_colour, req1_valid, req1_colour,
        output req0_ready, rsp0_valid, rsp0_rgb,
        output req1_ready, rsp1_valid, rsp1_rgb
    );
endinterface

// File: rtl/rgb_rom_arbiter.sv
// rgb_rom_arbiter: shares one single-port colour ROM (registered output,
// ROM_LAT cycles of read latency) between two requesters with round-robin
// arbitration. One ROM read per cycle; each result comes back as a
// one-cycle pulse to the requester that issued it, in issue order.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : arbitration enable (in-flight reads still complete)
//   bus         : requester channels (slave modport of rgb_rom_arbiter_if)
//   rom_en      : ROM read enable, high in the grant cycle
//   rom_colour  : ROM address, granted colour or 0 when idle
//   rom_rgb     : ROM data out
//   busy        : high while any read is in flight
module rgb_rom_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    rgb_rom_arbiter_if.slave   bus,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_colour,
    input  logic [DATA_W-1:0]  rom_rgb,
    output logic               busy
);
    logic              gnt_vld;
    logic              gnt_id;
    logic              last_grant_q, last_grant_d;

    // In-flight tracking: stage k holds the read accepted k+1 edges ago.
    // Stage ROM_LAT-1 lines up with valid rom_rgb; stage ROM_LAT is the
    // cycle in which the response pulse is on the outputs.
    logic [ROM_LAT:0]  vld_pipe_q, vld_pipe_d;
    logic [ROM_LAT:0]  id_pipe_q,  id_pipe_d;

    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rgb_q,   rsp0_rgb_d;
    logic [DATA_W-1:0] rsp1_rgb_q,   rsp1_rgb_d;

    // Grant: sole requester wins; on contention the one not granted last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!rst && en) begin
            case ({bus.req1_valid, bus.req0_valid})
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~last_grant_q;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = gnt_vld & ~gnt_id;
    assign bus.req1_ready = gnt_vld &  gnt_id;
    assign rom_en         = gnt_vld;
    assign rom_colour     = !gnt_vld ? '0 :
                            (gnt_id ? bus.req1_colour : bus.req0_colour);

    always_comb begin
        last_grant_d = gnt_vld ? gnt_id : last_grant_q;
        vld_pipe_d   = {vld_pipe_q[ROM_LAT-1:0], gnt_vld};
        id_pipe_d    = {id_pipe_q[ROM_LAT-1:0],  gnt_id};
        // rom_rgb is valid now for the read sitting in stage ROM_LAT-1.
        rsp0_valid_d = vld_pipe_q[ROM_LAT-1] & ~id_pipe_q[ROM_LAT-1];
        rsp1_valid_d = vld_pipe_q[ROM_LAT-1] &  id_pipe_q[ROM_LAT-1];
        rsp0_rgb_d   = rsp0_valid_d ? rom_rgb : rsp0_rgb_q;
        rsp1_rgb_d   = rsp1_valid_d ? rom_rgb : rsp1_rgb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rgb_q   <= '0;
            rsp1_rgb_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_pipe_q   <= vld_pipe_d;
            id_pipe_q    <= id_pipe_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rgb_q   <= rsp0_rgb_d;
            rsp1_rgb_q   <= rsp1_rgb_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rgb   = rsp0_rgb_q;
    assign bus.rsp1_rgb   = rsp1_rgb_q;
    assign busy           = |vld_pipe_q;
endmodule

// File: tb/tb_rgb_rom_arbiter.sv
module tb_rgb_rom_arbiter;
    localparam logic [23:0] ROM_TBL [8] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic        rom_en_a, rom_en_b, busy_a, busy_b;
    logic [2:0]  rom_colour_a, rom_colour_b;
    logic [23:0] rom_rgb_a;
    logic [23:0] rom_b_q [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rgb_rom_arbiter_if #(.ADDR_W(3), .DATA_W(24)) bus_a ();
    rgb_rom_arbiter_if #(.ADDR_W(3), .DATA_W(24)) bus_b ();

    rgb_rom_arbiter #(.ADDR_W(3), .DATA_W(24), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .bus(bus_a),
        .rom_en(rom_en_a), .rom_colour(rom_colour_a),
        .rom_rgb(rom_rgb_a), .busy(busy_a)
    );

    rgb_rom_arbiter #(.ADDR_W(3), .DATA_W(24), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .bus(bus_b),
        .rom_en(rom_en_b), .rom_colour(rom_colour_b),
        .rom_rgb(rom_b_q[2]), .busy(busy_b)
    );

    // ROM stand-ins: 1-cycle and 3-cycle registered read paths.
    always @(posedge clk) if (rom_en_a) rom_rgb_a <= ROM_TBL[rom_colour_a];
    always @(posedge clk) begin
        if (rom_en_b) rom_b_q[0] <= ROM_TBL[rom_colour_b];
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic go();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        bus_a.req0_valid = 1'b0; bus_a.req0_colour = '0;
        bus_a.req1_valid = 1'b0; bus_a.req1_colour = '0;
        bus_b.req0_valid = 1'b0; bus_b.req0_colour = '0;
        bus_b.req1_valid = 1'b0; bus_b.req1_colour = '0;
        go();

        // Reset state, with a request pending while rst is high.
        bus_a.req0_valid = 1'b1; bus_a.req0_colour = 3'd3; #1;
        chk("rst_ready0", bus_a.req0_ready, 1'b0);
        chk("rst_rom_en", rom_en_a, 1'b0);
        chk("rst_rsp0_valid", bus_a.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus_a.rsp1_valid, 1'b0);
        chk("rst_rsp0_rgb", bus_a.rsp0_rgb, 24'h0);
        chk("rst_busy", busy_a, 1'b0);
        go();

        // 1: single lookup, colour 3.
        rst = 1'b0; #1;
        chk("t1_ready0", bus_a.req0_ready, 1'b1);
        chk("t1_ready1", bus_a.req1_ready, 1'b0);
        chk("t1_rom_en", rom_en_a, 1'b1);
        chk("t1_rom_colour", rom_colour_a, 3'd3);
        go();
        bus_a.req0_valid = 1'b0; #1;
        chk("t1_rsp0_early", bus_a.rsp0_valid, 1'b0);
        chk("t1_busy", busy_a, 1'b1);
        chk("t1_idle_colour", rom_colour_a, 3'd0);
        go(); #1;
        chk("t1_rsp0_valid", bus_a.rsp0_valid, 1'b1);
        chk("t1_rsp0_rgb", bus_a.rsp0_rgb, 24'h0000FF);
        chk("t1_rsp1_valid", bus_a.rsp1_valid, 1'b0);
        go(); #1;
        chk("t1_rsp0_drop", bus_a.rsp0_valid, 1'b0);
        chk("t1_rgb_hold", bus_a.rsp0_rgb, 24'h0000FF);
        chk("t1_busy_end", busy_a, 1'b0);
        go();

        // 2: contention, colours 1 and 6, after a fresh reset.
        rst = 1'b1; #1;
        go();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_a.req0_valid = (k < 4); bus_a.req0_colour = 3'd1;
            bus_a.req1_valid = (k < 4); bus_a.req1_colour = 3'd6;
            #1;
            chk("t2_ready0", bus_a.req0_ready, (k < 4) && (k % 2 == 0));
            chk("t2_ready1", bus_a.req1_ready, (k < 4) && (k % 2 == 1));
            chk("t2_rsp0_valid", bus_a.rsp0_valid, (k >= 2) && (k % 2 == 0));
            chk("t2_rsp1_valid", bus_a.rsp1_valid, (k >= 2) && (k % 2 == 1));
            if (k >= 2 && k % 2 == 0) chk("t2_rsp0_rgb", bus_a.rsp0_rgb, 24'hFF0000);
            if (k >= 2 && k % 2 == 1) chk("t2_rsp1_rgb", bus_a.rsp1_rgb, 24'h00FFFF);
            go();
        end

        // 3: requester 1 streams colours 0..7 alone.
        for (int k = 0; k < 10; k++) begin
            bus_a.req1_valid = (k < 8); bus_a.req1_colour = 3'(k);
            #1;
            chk("t3_ready1", bus_a.req1_ready, k < 8);
            chk("t3_rom_colour", rom_colour_a, (k < 8) ? 3'(k) : 3'd0);
            chk("t3_rsp1_valid", bus_a.rsp1_valid, k >= 2);
            chk("t3_rsp0_valid", bus_a.rsp0_valid, 1'b0);
            chk("t3_busy", busy_a, k >= 1);
            if (k >= 2) chk("t3_rsp1_rgb", bus_a.rsp1_rgb, ROM_TBL[k-2]);
            go();
        end

        // 4: enable gating after reset, then en dropped with reads in flight.
        rst = 1'b1; #1;
        go();
        rst = 1'b0; en = 1'b0;
        bus_a.req0_valid = 1'b1; bus_a.req0_colour = 3'd2;
        bus_a.req1_valid = 1'b1; bus_a.req1_colour = 3'd4;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_gated_ready0", bus_a.req0_ready, 1'b0);
            chk("t4_gated_ready1", bus_a.req1_ready, 1'b0);
            chk("t4_gated_rom_en", rom_en_a, 1'b0);
            go();
        end
        en = 1'b1; #1;
        chk("t4_first_ready0", bus_a.req0_ready, 1'b1);
        chk("t4_first_colour", rom_colour_a, 3'd2);
        go(); #1;
        chk("t4_second_ready1", bus_a.req1_ready, 1'b1);
        chk("t4_second_ready0", bus_a.req0_ready, 1'b0);
        chk("t4_second_colour", rom_colour_a, 3'd4);
        go();
        en = 1'b0; #1;
        chk("t4_off_ready0", bus_a.req0_ready, 1'b0);
        chk("t4_off_rom_en", rom_en_a, 1'b0);
        chk("t4_rsp0_valid", bus_a.rsp0_valid, 1'b1);
        chk("t4_rsp0_rgb", bus_a.rsp0_rgb, 24'h00FF00);
        go(); #1;
        chk("t4_rsp1_valid", bus_a.rsp1_valid, 1'b1);
        chk("t4_rsp1_rgb", bus_a.rsp1_rgb, 24'hFFFF00);
        chk("t4_rsp0_drop", bus_a.rsp0_valid, 1'b0);
        go();
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0; en = 1'b1; #1;
        chk("t4_rsp1_drop", bus_a.rsp1_valid, 1'b0);
        chk("t4_busy_end", busy_a, 1'b0);
        go();

        // 5: reset lands while a read is in flight.
        bus_a.req0_valid = 1'b1; bus_a.req0_colour = 3'd5; #1;
        chk("t5_ready0", bus_a.req0_ready, 1'b1);
        go();
        bus_a.req0_valid = 1'b0; rst = 1'b1; #1;
        chk("t5_busy_inflight", busy_a, 1'b1);
        go();
        rst = 1'b0; #1;
        chk("t5_rsp0_valid", bus_a.rsp0_valid, 1'b0);
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_rsp0_rgb", bus_a.rsp0_rgb, 24'h0);
        go(); #1;
        chk("t5_no_late_pulse", bus_a.rsp0_valid, 1'b0);
        go();

        // 6: ROM_LAT=3 instance, single lookup then three back-to-back.
        for (int k = 0; k < 5; k++) begin
            bus_b.req0_valid = (k == 0); bus_b.req0_colour = 3'd7;
            #1;
            if (k == 0) chk("t6_ready0", bus_b.req0_ready, 1'b1);
            chk("t6_rsp0_valid", bus_b.rsp0_valid, k == 4);
            if (k == 4) chk("t6_rsp0_rgb", bus_b.rsp0_rgb, 24'hFFFFFF);
            go();
        end
        for (int k = 0; k < 8; k++) begin
            bus_b.req0_valid = (k < 3); bus_b.req0_colour = 3'(k + 1);
            #1;
            chk("t6b_ready0", bus_b.req0_ready, k < 3);
            chk("t6b_rsp0_valid", bus_b.rsp0_valid, (k >= 4) && (k <= 6));
            chk("t6b_busy", busy_b, (k >= 1) && (k <= 6));
            if (k >= 4 && k <= 6) chk("t6b_rsp0_rgb", bus_b.rsp0_rgb, ROM_TBL[k-3]);
            go();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
